// File: rtl/ifetch_pkg.sv
// Shared constants and types for the instruction fetch front end.
package ifetch_pkg;

  localparam int unsigned IF_ADDR_W = 10;
  localparam int unsigned IF_DATA_W = 32;

  localparam logic [IF_DATA_W-1:0] NOP_INSTR = '0;

  typedef enum logic [0:0] {
    ST_BOOT = 1'b0,
    ST_RUN  = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [IF_DATA_W-1:0] instr;
    logic [IF_ADDR_W-1:0] pc;
  } fetch_entry_t;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with flush; the head entry is presented combinationally.
module sync_fifo
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = $bits(fetch_entry_t)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   i_push,
  input  logic                   i_pop,
  input  logic                   i_flush,
  input  logic [WIDTH-1:0]       i_wdata,
  output logic [WIDTH-1:0]       o_head,
  output logic [$clog2(DEPTH):0] o_count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic             w_pop;

  // A pop on an empty queue is ignored so the pointers never drift.
  assign w_pop = i_pop && (r_count != '0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else if (i_flush) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (i_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      end
      unique case ({i_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (i_push && !i_flush) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/ifetch_queue.sv
// Instruction fetch front end: issues instruction memory reads and queues the
// returned words, tagged with their PC, for the decode stage.
module ifetch_queue
  import ifetch_pkg::*;
#(
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned ADDR_W = IF_ADDR_W,
  parameter int unsigned DATA_W = IF_DATA_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  input  logic              stall,
  output logic              IM_read,
  output logic              IM_write,
  output logic              IM_enable,
  output logic [ADDR_W-1:0] IM_address,
  input  logic [DATA_W-1:0] IM_dout,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr_out,
  output logic [ADDR_W-1:0] instr_pc
);

  localparam int unsigned CNT_W = $clog2(DEPTH) + 1;
  localparam int unsigned CW1   = CNT_W + 1;
  localparam int unsigned ENT_W = DATA_W + ADDR_W;

  fetch_state_e      r_state;
  fetch_state_e      w_state_nxt;
  logic [ADDR_W-1:0] r_fetch_pc;
  logic              r_im_read;
  logic [ADDR_W-1:0] r_im_addr;
  logic              r_inflight;
  logic [ADDR_W-1:0] r_inflight_pc;
  logic              r_kill;
  logic              w_issue;
  logic              w_push;
  logic              w_pop;
  logic [CNT_W-1:0]  w_count;
  logic [CW1-1:0]    w_committed;
  logic [ENT_W-1:0]  w_head;

  // Slots already promised: queued words, the read on the bus now and the
  // word returning now; a new read is allowed only if a slot remains.
  assign w_committed = {1'b0, w_count} + CW1'(r_im_read) + CW1'(r_inflight);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= ST_BOOT;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_issue     = 1'b0;
    unique case (r_state)
      ST_BOOT: w_state_nxt = ST_RUN;
      ST_RUN:  w_issue     = !redirect && (w_committed < CW1'(DEPTH));
      default: w_state_nxt = ST_BOOT;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_fetch_pc    <= '0;
      r_im_read     <= 1'b0;
      r_im_addr     <= '0;
      r_inflight    <= 1'b0;
      r_inflight_pc <= '0;
      r_kill        <= 1'b0;
    end else begin
      r_im_read     <= w_issue;
      r_inflight    <= r_im_read;
      r_inflight_pc <= r_im_addr;
      // The read on the bus during a redirect returns next cycle as stale data.
      r_kill        <= redirect && r_im_read;
      if (w_issue) begin
        r_im_addr <= r_fetch_pc;
      end
      if (redirect) begin
        r_fetch_pc <= redirect_pc;
      end else if (w_issue) begin
        r_fetch_pc <= r_fetch_pc + ADDR_W'(1);
      end
    end
  end

  assign w_push = r_inflight && !r_kill && !redirect;
  assign w_pop  = instr_valid && !stall && !redirect;

  sync_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (ENT_W)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_flush (redirect),
    .i_wdata ({IM_dout, r_inflight_pc}),
    .o_head  (w_head),
    .o_count (w_count)
  );

  assign IM_read     = r_im_read;
  assign IM_address  = r_im_addr;
  assign IM_write    = 1'b0;
  assign IM_enable   = 1'b1;
  assign instr_valid = (w_count != '0);
  assign instr_out   = instr_valid ? w_head[ENT_W-1:ADDR_W] : DATA_W'(NOP_INSTR);
  assign instr_pc    = instr_valid ? w_head[ADDR_W-1:0] : '0;

endmodule

// File: tb/tb_ifetch_queue.sv
// Scoreboard bench for ifetch_queue: directed boot/stall/redirect/reset cases
// followed by randomised stall and redirect traffic.
module tb_ifetch_queue;
  import ifetch_pkg::*;

  localparam int unsigned DEPTH  = 4;
  localparam int unsigned ADDR_W = 10;
  localparam int unsigned DATA_W = 32;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              redirect = 1'b0;
  logic [ADDR_W-1:0] redirect_pc = '0;
  logic              stall = 1'b0;
  logic              IM_read;
  logic              IM_write;
  logic              IM_enable;
  logic [ADDR_W-1:0] IM_address;
  logic [DATA_W-1:0] IM_dout = '0;
  logic              instr_valid;
  logic [DATA_W-1:0] instr_out;
  logic [ADDR_W-1:0] instr_pc;

  int           checks = 0;
  int           errors = 0;
  int           seg_age = 0;
  fetch_entry_t exp_q[$];
  fetch_entry_t mon_e;

  ifetch_queue #(
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W),
    .DATA_W (DATA_W)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .stall       (stall),
    .IM_read     (IM_read),
    .IM_write    (IM_write),
    .IM_enable   (IM_enable),
    .IM_address  (IM_address),
    .IM_dout     (IM_dout),
    .instr_valid (instr_valid),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] mem_word(input logic [ADDR_W-1:0] a);
    return 32'hA000_0000 + DATA_W'(a);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h required 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expected delivery after a restart: consecutive PCs from the base, wrapping.
  task automatic restart_stream(input logic [ADDR_W-1:0] base);
    logic [ADDR_W-1:0] p;
    p = base;
    exp_q.delete();
    for (int i = 0; i < 96; i++) begin
      exp_q.push_back('{instr: mem_word(p), pc: p});
      p = p + ADDR_W'(1);
    end
    seg_age = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Instruction memory: data is valid one cycle after the read, garbage otherwise.
  always @(posedge clk) begin : imem
    logic              rd;
    logic [ADDR_W-1:0] a;
    rd = IM_read;
    a  = IM_address;
    #1;
    IM_dout = rd ? mem_word(a) : DATA_W'($urandom());
  end

  always @(negedge clk) begin
    if (rst) begin
      chk("im_write", 64'(IM_write), 64'd0);
      chk("im_enable", 64'(IM_enable), 64'd1);
      if (!instr_valid) begin
        chk("idle_head_zero", 64'({instr_out, instr_pc}), 64'd0);
      end else if (!stall && !redirect) begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: got pc 0x%0h required no delivery at %0t", instr_pc, $time);
        end else begin
          mon_e = exp_q.pop_front();
          chk("head_pc", 64'(instr_pc), 64'(mon_e.pc));
          chk("head_instr", 64'(instr_out), 64'(mon_e.instr));
        end
      end
    end
  end

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_im_read"}, 64'(IM_read), 64'd0);
    chk({tag, "_im_addr"}, 64'(IM_address), 64'd0);
    chk({tag, "_valid"}, 64'(instr_valid), 64'd0);
    chk({tag, "_instr"}, 64'(instr_out), 64'd0);
    chk({tag, "_pc"}, 64'(instr_pc), 64'd0);
  endtask

  // Called just after rst is released; the next edge is cycle 0.
  task automatic boot_check();
    step();
    chk("boot_c0_no_read", 64'(IM_read), 64'd0);
    step();
    chk("boot_c1_read", 64'(IM_read), 64'd1);
    chk("boot_c1_addr", 64'(IM_address), 64'd0);
    step();
    chk("boot_c2_read", 64'(IM_read), 64'd1);
    chk("boot_c2_addr", 64'(IM_address), 64'd1);
    chk("boot_c2_valid", 64'(instr_valid), 64'd0);
    step();
    chk("boot_c3_valid", 64'(instr_valid), 64'd1);
    chk("boot_c3_pc", 64'(instr_pc), 64'd0);
    chk("boot_c3_instr", 64'(instr_out), 64'hA000_0000);
  endtask

  task automatic redirect_check(input logic [ADDR_W-1:0] tgt);
    redirect    = 1'b1;
    redirect_pc = tgt;
    restart_stream(tgt);
    step();
    redirect    = 1'b0;
    stall       = 1'b0;
    redirect_pc = ADDR_W'($urandom());
    chk("rd_t1_valid", 64'(instr_valid), 64'd0);
    step();
    chk("rd_t2_read", 64'(IM_read), 64'd1);
    chk("rd_t2_addr", 64'(IM_address), 64'(tgt));
    step();
    chk("rd_t3_valid", 64'(instr_valid), 64'd0);
    step();
    chk("rd_t4_valid", 64'(instr_valid), 64'd1);
    chk("rd_t4_pc", 64'(instr_pc), 64'(tgt));
  endtask

  initial begin
    logic [ADDR_W-1:0] h_pc;
    logic [ADDR_W-1:0] tgt;

    restart_stream('0);
    repeat (3) @(posedge clk);
    #1;
    chk_reset_outputs("por");
    rst = 1'b1;
    boot_check();
    for (int i = 0; i < 12; i++) begin
      step();
      chk("steady_valid", 64'(instr_valid), 64'd1);
    end

    stall = 1'b1;
    h_pc  = instr_pc;
    for (int i = 0; i < 10; i++) begin
      step();
      chk("stall_head_hold", 64'(instr_pc), 64'(h_pc));
      if (i >= 3) chk("stall_no_read", 64'(IM_read), 64'd0);
    end
    stall = 1'b0;
    for (int i = 0; i < 12; i++) begin
      step();
      chk("post_stall_valid", 64'(instr_valid), 64'd1);
    end

    chk("read_in_flight", 64'(IM_read), 64'd1);
    redirect_check(10'h200);
    repeat (4) step();

    stall = 1'b1;
    repeat (8) step();
    chk("full_no_read", 64'(IM_read), 64'd0);
    chk("full_valid", 64'(instr_valid), 64'd1);
    tgt = ADDR_W'($urandom());
    redirect_check(tgt);
    repeat (3) step();

    redirect_check(10'h3FF);
    step();
    chk("wrap_pc", 64'(instr_pc), 64'd0);
    chk("wrap_instr", 64'(instr_out), 64'hA000_0000);
    repeat (3) step();

    stall = 1'b1;
    repeat (2) step();
    chk("pre_reset_valid", 64'(instr_valid), 64'd1);
    @(negedge clk);
    #2;
    rst = 1'b0;
    restart_stream('0);
    #1;
    chk_reset_outputs("midrst");
    @(posedge clk);
    #1;
    stall = 1'b0;
    rst   = 1'b1;
    boot_check();

    for (int i = 0; i < 600; i++) begin
      seg_age++;
      if (seg_age > 50 || $urandom_range(0, 19) == 0) begin
        tgt         = ADDR_W'($urandom());
        redirect    = 1'b1;
        redirect_pc = tgt;
        restart_stream(tgt);
      end else begin
        redirect    = 1'b0;
        redirect_pc = ADDR_W'($urandom());
      end
      stall = ($urandom_range(0, 3) == 0);
      step();
    end
    redirect = 1'b0;
    stall    = 1'b0;
    repeat (8) step();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
